mux_nx1_arb: RTL
================

Name: mux_nx1_arb

Overview:
- Parametrised N-input to 1-output registered multiplexer with per-channel valid, downstream backpressure and a selectable arbitration mode.
- Generalises the team's 2:1 flopped mux: adds channel count, data width, a round-robin mode, a consume handshake (pop) toward the sources, and a channel tag on the output.
- Sits between the per-lane FIFOs and the shared serialiser / output path of the datapath.

Parameters:
- DATA_W, 8, width of each data word.
- NUM_IN, 4, number of input channels (2..16).
- MODE, 1, 0 = fixed selector (2:1 behaviour generalised), 1 = round-robin over valid inputs.
- SEL_W, $clog2(NUM_IN) (minimum 1), derived width of selector and channel tag; do not override.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- Entradas  in  NUM_IN*DATA_W  packed input data; channel i at [i*DATA_W +: DATA_W].
- validEntradas  in  NUM_IN  per-channel valid.
- selector  in  SEL_W  channel choice, used only when MODE=0.
- readySalida  in  1  downstream can accept the word in the output register this cycle.
- popEntradas  out  NUM_IN  one-hot combinational consume strobe to the sources; at most one bit high.
- Salida  out  DATA_W  registered output data.
- validSalida  out  1  Salida holds a word not yet accepted.
- canalSalida  out  SEL_W  index of the channel Salida came from.

Behaviour:
- Reset (reset=0, asynchronous): Salida=0, validSalida=0, canalSalida=0, round-robin pointer last_grant=NUM_IN-1 (channel 0 wins first), popEntradas=0.
- load_en = !validSalida || readySalida. The output register accepts a new word only when load_en=1.
- Grant (combinational):
  - MODE=0: grant channel selector if validEntradas[selector]=1 and selector<NUM_IN. Otherwise no grant. A selector value >= NUM_IN is never granted.
  - MODE=1: first valid channel scanning last_grant+1, last_grant+2, ... with modulo NUM_IN wrap. If no channel is valid, no grant.
- popEntradas[g] = grant_valid && load_en && reset. A pop means the source must advance next cycle.
- On a clock edge with load_en=1:
  - If grant_valid: Salida<=data[g], canalSalida<=g, validSalida<=1, and (MODE=1 only) last_grant<=g.
  - If no grant: validSalida<=0. Salida and canalSalida hold their values; they are don't-care.
- On a clock edge with load_en=0 (stall): Salida, canalSalida, validSalida and last_grant hold. popEntradas=0.
- Latency: 1 cycle from pop to validSalida. Throughput is 1 word/cycle while readySalida=1.
- Simultaneous accept and load: validSalida stays 1 and the new word replaces the old in the same edge. No bubble.
- Fairness (MODE=1): with all channels continuously valid and ready=1, the grant order is 0,1,...,NUM_IN-1,0,...
- A channel dropping valid while stalled does not affect Salida, which was already captured.
- Reset asserted mid-stall discards the held word. After release, the first grant follows the reset pointer.
- MODE is static; changing it at runtime is not supported.

Decomposition:
- Shared package mux_pkg: mode constants MODE_FIXED=0 and MODE_RR=1, and a clog2-with-minimum-1 function for SEL_W.
- One natural sub-module, rr_arbiter: NUM_IN request vector plus last_grant in, one-hot grant plus index out, purely combinational.
- The output register, load_en logic and the pointer register live in mux_nx1_arb.

Test Plan:
- Reset: hold reset=0 with all valids=1, then release. During reset, popEntradas=0, validSalida=0, Salida=0. On the first edge after release (MODE=1, NUM_IN=4), popEntradas=4'b0001, and next cycle Salida=ch0 data, canalSalida=0.
- Round-robin fairness: inputs 0xA0..0xA3 always valid, readySalida=1. Salida sequence is A0,A1,A2,A3,A0; canalSalida is 0,1,2,3,0; popEntradas is one-hot every cycle.
- Sparse requests: only ch1 and ch3 valid (0x11, 0x33) with last_grant=1. Grants go 3,1,3; channels 0 and 2 are never popped.
- Backpressure: readySalida=0 for 3 cycles while Salida=0x22. Salida, canalSalida and validSalida stay stable, popEntradas=0. On the ready=1 cycle the next word loads on the same edge, with no bubble.
- Fixed mode (MODE=0, NUM_IN=2): selector=1, Entradas={0x5A,0x3C}, both valid. Salida=0x5A, pop=2'b10. With validEntradas[1]=0, validSalida=0 and no pop.
- Async reset mid-stall: reset=0 between clock edges while validSalida=1. validSalida and Salida go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the N:1 registered mux
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Selector/tag width; a 1-channel or 2-channel mux still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nx1_rr_arbiter.sv
// rtl/mux_nx1_rr_arbiter.sv - combinational round-robin arbiter starting after last_grant
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  last_grant_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SEL_W-1:0]  grant_idx_o,
    output logic              grant_valid_o
);

    int idx;

    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        // Offset NUM_IN wraps back to last_grant itself, so it is checked last.
        for (int off = 1; off <= NUM_IN; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_IN;
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = SEL_W'(idx);
                grant_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_arb.sv
// rtl/mux_nx1_arb.sv - N:1 registered mux with fixed or round-robin arbitration and pop handshake
module mux_nx1_arb
    import mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_IN = 4,
    parameter int MODE   = MODE_RR,
    parameter int SEL_W  = clog2_min1(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_IN*DATA_W-1:0] Entradas,
    input  logic [NUM_IN-1:0]        validEntradas,
    input  logic [SEL_W-1:0]         selector,
    input  logic                     readySalida,
    output logic [NUM_IN-1:0]        popEntradas,
    output logic [DATA_W-1:0]        Salida,
    output logic                     validSalida,
    output logic [SEL_W-1:0]         canalSalida
);

    logic [DATA_W-1:0] salida_q, salida_d;
    logic              valid_q, valid_d;
    logic [SEL_W-1:0]  canal_q, canal_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;

    logic [NUM_IN-1:0] rr_grant, fix_grant, grant_vec;
    logic [SEL_W-1:0]  rr_idx, grant_idx;
    logic              rr_valid, grant_valid, load_en;
    logic [DATA_W-1:0] grant_data;

    rr_arbiter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_rr (
        .req_i        (validEntradas),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .grant_idx_o  (rr_idx),
        .grant_valid_o(rr_valid)
    );

    // Comparing against each in-range index means selector >= NUM_IN never grants.
    always_comb begin
        fix_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            fix_grant[i] = validEntradas[i] && (selector == SEL_W'(i));
        end
    end

    assign grant_vec   = (MODE == MODE_RR) ? rr_grant : fix_grant;
    assign grant_idx   = (MODE == MODE_RR) ? rr_idx   : selector;
    assign grant_valid = (MODE == MODE_RR) ? rr_valid : (|fix_grant);
    assign load_en     = !valid_q || readySalida;
    assign popEntradas = (grant_valid && load_en && reset) ? grant_vec : '0;

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = Entradas[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        salida_d     = salida_q;
        valid_d      = valid_q;
        canal_d      = canal_q;
        last_grant_d = last_grant_q;
        if (load_en) begin
            valid_d = grant_valid;
            if (grant_valid) begin
                salida_d = grant_data;
                canal_d  = grant_idx;
                if (MODE == MODE_RR) begin
                    last_grant_d = grant_idx;
                end
            end
        end
    end

    // Pointer resets to the last channel so channel 0 wins the first round.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            salida_q     <= '0;
            valid_q      <= 1'b0;
            canal_q      <= '0;
            last_grant_q <= SEL_W'(NUM_IN - 1);
        end else begin
            salida_q     <= salida_d;
            valid_q      <= valid_d;
            canal_q      <= canal_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign Salida      = salida_q;
    assign validSalida = valid_q;
    assign canalSalida = canal_q;

endmodule
